// File: rtl/ofifo_pkg.sv
// Shared constants and pointer sizing for the array output buffer and its column FIFOs.
package ofifo_pkg;

   localparam int unsigned COL   = 8;
   localparam int unsigned BW    = 16;
   localparam int unsigned DEPTH = 64;

   // Address bits plus one wrap bit, so full and empty stay distinguishable.
   function automatic int unsigned ptr_w(input int unsigned d);
      return $clog2(d) + 1;
   endfunction

endpackage

// File: rtl/ofifo_col.sv
// One column FIFO with first-word-fall-through head, wrap-bit full/empty detection.
module ofifo_col
   import ofifo_pkg::*;
#(
   parameter int unsigned DW      = BW,
   parameter int unsigned DEPTH_N = DEPTH
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          wr_i,
   input  logic          rd_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o,
   output logic          empty_o,
   output logic          full_o
);

   localparam int unsigned PW = ptr_w(DEPTH_N);
   localparam int unsigned AW = PW - 1;

   logic [DW-1:0] mem_q [DEPTH_N];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_i) rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is never cleared; a write at full lands on the slot being popped.
   always_ff @(posedge clk_i) begin
      if (rst_ni && wr_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

endmodule

// File: rtl/ofifo.sv
// Per-column psum FIFOs with a row-wide pop that fires only when every column holds data.
module ofifo
   import ofifo_pkg::*;
#(
   parameter int unsigned col   = COL,
   parameter int unsigned bw    = BW,
   parameter int unsigned depth = DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [col*bw-1:0] in,
   input  logic [col-1:0]    wr,
   input  logic              rd,
   output logic [col*bw-1:0] out,
   output logic              o_valid,
   output logic              o_full,
   output logic              o_ready,
   output logic              o_overflow
);

   logic [col-1:0]    empty;
   logic [col-1:0]    full;
   logic [col-1:0]    accept;
   logic [col*bw-1:0] head;
   logic              pop;
   logic              overflow_q, overflow_d;

   for (genvar g = 0; g < col; g++) begin : g_col
      ofifo_col #(
         .DW      (bw),
         .DEPTH_N (depth)
      ) u_col (
         .clk_i   (clk),
         .rst_ni  (reset),
         .wr_i    (accept[g]),
         .rd_i    (pop),
         .data_i  (in[g*bw +: bw]),
         .data_o  (head[g*bw +: bw]),
         .empty_o (empty[g]),
         .full_o  (full[g])
      );
   end

   assign o_valid = &(~empty);
   assign o_full  = |full;
   assign o_ready = ~o_full;
   assign pop     = rd & o_valid;
   // A pop frees a slot in every column this same edge, so a full column may still accept.
   assign accept  = wr & (~full | {col{pop}});
   assign out     = o_valid ? head : '0;

   assign overflow_d = overflow_q | (|(wr & ~accept));

   always_ff @(posedge clk) begin
      if (!reset) overflow_q <= 1'b0;
      else        overflow_q <= overflow_d;
   end

   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo: vector table, directed corner sequences, randomized run vs a queue model.
module tb_ofifo;

   localparam int unsigned COLN = 8;
   localparam int unsigned BWN  = 16;
   localparam int unsigned DN   = 64;
   localparam int unsigned W    = COLN * BWN;

   logic          clk;
   logic          reset;
   logic [W-1:0]  in;
   logic [COLN-1:0] wr;
   logic          rd;
   logic [W-1:0]  out;
   logic          o_valid, o_full, o_ready, o_overflow;

   ofifo #(.col(COLN), .bw(BWN), .depth(DN)) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in),
      .wr         (wr),
      .rd         (rd),
      .out        (out),
      .o_valid    (o_valid),
      .o_full     (o_full),
      .o_ready    (o_ready),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   // Reference: one queue per column, plus the sticky drop flag.
   logic [BWN-1:0] mq [COLN][$];
   logic           m_ovf = 1'b0;
   bit             model_ok = 1'b0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      else pass_cnt++;
   endtask

   task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else pass_cnt++;
   endtask

   function automatic logic [W-1:0] row(input logic [BWN-1:0] base);
      logic [W-1:0] r;
      for (int i = 0; i < COLN; i++) r[i*BWN +: BWN] = base + BWN'(i);
      return r;
   endfunction

   task automatic check_model();
      bit v, f;
      logic [W-1:0] e;
      v = 1'b1; f = 1'b0; e = '0;
      for (int i = 0; i < COLN; i++) begin
         if (mq[i].size() == 0) v = 1'b0;
         if (mq[i].size() == DN) f = 1'b1;
      end
      if (v) for (int i = 0; i < COLN; i++) e[i*BWN +: BWN] = mq[i][0];
      chk1("m_valid", o_valid, v);
      chk1("m_full", o_full, f);
      chk1("m_ready", o_ready, !f);
      chk1("m_overflow", o_overflow, m_ovf);
      chkw("m_out", out, e);
   endtask

   task automatic model_update(input logic [COLN-1:0] w, input logic r,
                               input logic [W-1:0] d, input logic rs);
      bit v, p;
      int unsigned sz;
      if (!rs) begin
         for (int i = 0; i < COLN; i++) mq[i].delete();
         m_ovf = 1'b0;
         model_ok = 1'b1;
         return;
      end
      v = 1'b1;
      for (int i = 0; i < COLN; i++) if (mq[i].size() == 0) v = 1'b0;
      p = r && v;
      for (int i = 0; i < COLN; i++) begin
         sz = mq[i].size();
         if (p) void'(mq[i].pop_front());
         if (w[i]) begin
            if (sz < DN || p) mq[i].push_back(d[i*BWN +: BWN]);
            else m_ovf = 1'b1;
         end
      end
   endtask

   // Drive one cycle: inputs set just after an edge, outputs checked, edge taken, back to edge+1.
   task automatic step(input logic [COLN-1:0] w, input logic r, input logic [W-1:0] d, input logic rs);
      wr = w; rd = r; in = d; reset = rs;
      #1;
      if (model_ok) check_model();
      model_update(w, r, d, rs);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [COLN-1:0] wr;
      logic            rd;
      logic            exp_valid;
      logic [W-1:0]    exp_out;
   } vec_t;

   vec_t         vt [17];
   logic [W-1:0] skew_in;
   int unsigned  popcnt;
   int unsigned  pw, pr;
   logic [COLN-1:0] rw;

   initial begin
      wr = '0; rd = 1'b0; in = '0; reset = 1'b1;
      skew_in = row(16'h0100);
      for (int k = 0; k < 17; k++) begin
         vt[k].wr        = (k < 16 && (k % 2) == 0) ? COLN'(1 << (k / 2)) : '0;
         vt[k].rd        = (k >= 15);
         vt[k].exp_valid = (k == 14);
         vt[k].exp_out   = (k == 14) ? skew_in : '0;
      end
      @(posedge clk); #1;

      // Reset held with traffic present
      step('1, 1'b1, row(16'h5555), 1'b0);
      step('1, 1'b1, row(16'h6666), 1'b0);
      chk1("rst_valid", o_valid, 1'b0);
      chk1("rst_full", o_full, 1'b0);
      chk1("rst_ready", o_ready, 1'b1);
      chk1("rst_overflow", o_overflow, 1'b0);
      chkw("rst_out", out, '0);

      // Skewed column fill, one column every other cycle
      step('0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 17; k++) begin
         step(vt[k].wr, vt[k].rd, skew_in, 1'b1);
         chk1("skew_valid", o_valid, vt[k].exp_valid);
         chkw("skew_out", out, vt[k].exp_out);
      end

      // Fill column 3, then one dropped write
      step('0, 1'b0, '0, 1'b0);
      for (int n = 0; n < 64; n++) begin
         step(8'h08, 1'b0, row(16'h3000 + 16'(n) - 16'd3), 1'b1);
         chk1("fill_valid", o_valid, 1'b0);
      end
      chk1("fill_full", o_full, 1'b1);
      chk1("fill_ready", o_ready, 1'b0);
      chk1("fill_noovf", o_overflow, 1'b0);
      step(8'h08, 1'b0, row(16'hDEAD), 1'b1);
      chk1("ovf_set", o_overflow, 1'b1);
      chk1("ovf_valid", o_valid, 1'b0);
      step(8'hF7, 1'b0, row(16'h0040), 1'b1);
      chk1("ovf_rowvalid", o_valid, 1'b1);
      chkw("ovf_col3_head", {112'd0, out[3*BWN +: BWN]}, {112'd0, 16'h3000});

      // Write at full together with a pop
      step('0, 1'b0, '0, 1'b0);
      for (int n = 0; n < 64; n++) step('1, 1'b0, row(16'(n * 8)), 1'b1);
      chk1("wfp_full", o_full, 1'b1);
      step('1, 1'b1, row(16'hA000), 1'b1);
      chk1("wfp_noovf", o_overflow, 1'b0);
      chk1("wfp_full_hold", o_full, 1'b1);
      for (int n = 0; n < 63; n++) step('0, 1'b1, '0, 1'b1);
      chk1("wfp_valid", o_valid, 1'b1);
      chkw("wfp_newword", out, row(16'hA000));

      // Streaming with wrap: five rows in flight, one write and one pop per cycle
      step('0, 1'b0, '0, 1'b0);
      popcnt = 0;
      for (int c = 0; c < 300; c++) begin
         if (c >= 5) begin
            chkw("stream_data", out, row(16'(popcnt * 8)));
            popcnt++;
         end
         chk1("stream_nofull", o_full, 1'b0);
         step('1, (c >= 5), row(16'(c * 8)), 1'b1);
      end

      // Reset with ten rows buffered
      for (int n = 0; n < 5; n++) step('1, 1'b0, row(16'h4000 + 16'(n * 8)), 1'b1);
      step('1, 1'b1, row(16'hBEEF), 1'b0);
      chk1("mid_rst_valid", o_valid, 1'b0);
      chkw("mid_rst_out", out, '0);
      step('1, 1'b0, row(16'h7000), 1'b1);
      chk1("mid_rst_valid2", o_valid, 1'b1);
      chkw("mid_rst_first", out, row(16'h7000));

      // Randomized phases of differing write/pop pressure against the queue model
      for (int ph = 0; ph < 15; ph++) begin
         pw = $urandom_range(10, 100);
         pr = $urandom_range(0, 100);
         for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < COLN; i++) rw[i] = ($urandom_range(0, 99) < pw);
            step(rw, ($urandom_range(0, 99) < pr), {$urandom, $urandom, $urandom, $urandom},
                 ($urandom_range(0, 599) != 0));
         end
      end
      step('0, 1'b0, '0, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ofifo.md
# ofifo

Output buffer at the bottom of the MAC array: the counterpart of the row-wise input L0 buffer. Each array column delivers partial sums independently through its own write strobe into a private first-word-fall-through FIFO. The downstream SRAM writer pops one full row across all columns at once, and only when every column holds data. Flow control back to the array is a single full/ready pair.

## Interface
- `col`, default 8: number of array columns, one FIFO per column.
- `bw`, default 16: psum width per column, in bits.
- `depth`, default 64: entries per column FIFO. Must be a power of 2 and at least 2.

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-low. Sampled at rising `clk`; `reset`=0 resets.
- `in`, input, col*bw: psum data. Column i occupies bits `[bw*(i+1)-1 : bw*i]`.
- `wr`, input, col: per-column write strobe.
- `rd`, input, 1: pop one word from every column.
- `out`, output, col*bw: head word of each column, same bit packing as `in`.
- `o_valid`, output, 1: every column is non-empty, so `out` is a complete row.
- `o_full`, output, 1: at least one column is full.
- `o_ready`, output, 1: equals `!o_full`.
- `o_overflow`, output, 1: sticky. Set when a write is dropped; cleared only by reset.

## Operation
- Per-column state:
  - write pointer and read pointer, each log2(depth)+1 bits wide; the extra MSB is the wrap bit.
  - storage array of `depth` x `bw`.
- Empty condition: pointers are equal.
- Full condition: the low bits are equal and the wrap bits differ.
- `pop` is defined as `rd & o_valid`. A `rd` while `o_valid`=0 is ignored, with no pointer change.
- On `pop`, every column's read pointer increments by 1, modulo 2*depth.
- A write to column i is accepted when `wr[i]` is high and either:
  - column i is not full, or
  - `pop` is asserted in the same cycle.
- An accepted write stores `in[i]` at the write pointer, then increments the write pointer.
- A write that is not accepted is dropped: storage and pointers are unchanged, and `o_overflow` is set on the next edge.
- Columns fill at different rates. `o_valid` holds off until the slowest column has data.
- `out` is combinational from the head entries when `o_valid`=1, and is forced to 0 when `o_valid`=0.
- `o_full` and `o_valid` are combinational from the pointers. They change only after clock edges, never directly from `wr` or `rd`.

## Timing
- Reset values, from the first edge with `reset`=0:
  - all pointers 0
  - `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0, `out`=0
  - storage contents not cleared
- Reset mid-operation discards all buffered data, and any `wr`/`rd` sampled in the same cycle are ignored.
- Write-to-read latency is 1 cycle. If the last empty column is written at edge N, `o_valid`=1 and `out` shows the row during the cycle after edge N.
- Pop: with `rd`=1 at edge N, `out` shows the next row after edge N, or 0 with `o_valid`=0 if any column has drained.
- Back-to-back pops, one per cycle, are sustained while all columns stay non-empty.
- Full column with `wr` and `pop` in the same cycle: both take effect, and occupancy stays at `depth`.
- Simultaneous `wr` and `pop` on an empty column cannot occur, because `pop` requires all columns to be non-empty.
- Pointer wrap: after 2*depth writes a pointer returns to 0, and full/empty detection stays correct.

## Structure
- `ofifo_pkg` holds:
  - default constants `COL`=8, `BW`=16, `DEPTH`=64
  - a `clog2`-based pointer-width function shared with the L0 buffer
- Sub-module `ofifo_col`: one column FIFO with FWFT head output, `o_empty`, and `o_full`.
  - Its write-accept input is computed in the top level, because it depends on `pop`.
  - The top level instantiates `col` copies in a generate loop.
- The top level owns the `o_valid` reduce-AND of non-empty flags, the `o_full` reduce-OR of full flags, the `pop` logic, output gating, and the sticky overflow flag.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `wr`=all ones and `rd`=1. Required after release: `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0, `out`=0.
- **Skewed columns:** write column i at cycle 2i with value 0x100+i (col=8). Required:
  - `o_valid` rises exactly one cycle after column 7 is written;
  - `out` reads 0x107..0x100 from MSB to LSB;
  - one `rd` returns `o_valid` to 0.
- **Fill and overflow:** write 64 words to column 3 only. Required:
  - `o_full`=1 and `o_ready`=0 after the 64th write;
  - a 65th write sets `o_overflow`=1 and leaves the column contents unchanged;
  - `o_valid` stays 0 throughout.
- **Streaming and wrap:** write all columns every cycle with an incrementing counter, and pop every cycle starting 5 cycles later, for 300 cycles. Required: popped data is in order with no gaps, `o_full` never asserts, and pointers wrap cleanly.
- **Write at full with pop:** fill all columns to 64, then in one cycle assert `wr`=all ones and `rd`=1. Required: no overflow, `o_full` stays 1, and the new word is popped 64 pops later.
- **Reset mid-stream:** with 10 rows buffered, pulse `reset`=0 for 1 cycle. Required: `o_valid`=0 next cycle, and the first row written afterwards is the first row read.
